spi_wb_target: RTL and testbench
================================

SPI_WB_TARGET -- requirements
Module: spi_wb_target

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 32: Wishbone address width.
REQ-002 SHALL have parameter DAT_WIDTH, default 32: Wishbone data width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth on sck/csb/sdi.
REQ-004 SHALL have parameter TIMEOUT, default 255: clocks allowed for a Wishbone ack.
REQ-005 SHALL use one clock and a synchronous, active-high reset; port list: wb_clk_i  in  1  clock; wb_rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have ports sck  in  1  SPI clock from initiator; csb  in  1  chip select, active-low; sdi  in  1  serial data from initiator.
REQ-007 SHALL have ports sdo  out  1  serial data to initiator; sdoenb  out  1  sdo output-enable, active-low.
REQ-008 SHALL have Wishbone initiator ports wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1; wbm_sel_o  out  4; wbm_adr_o  out  ADR_WIDTH; wbm_dat_o  out  DAT_WIDTH; wbm_dat_i  in  DAT_WIDTH; wbm_ack_i  in  1.
REQ-009 SHALL have ports busy  out  1  frame or WB cycle in progress; err  out  1  one-clock pulse on protocol/timeout error.

Function
REQ-010 SHALL implement SPI mode 0 (sample sdi on sck rise, change sdo on sck fall), MSB first, edges detected in wb_clk_i domain after SYNC_STAGES synchroniser.
REQ-011 SHALL require sck high/low phases >= SYNC_STAGES+3 clocks; sdo update SHALL occur SYNC_STAGES+1 clocks after sck fall at pin.
REQ-012 SHALL decode frames: cmd byte, 32-bit address, then write: 32 data bits; read: 8 dummy bits + 32 data bits.
REQ-013 SHALL accept cmd 0x02 = write, 0x03 = read; any other cmd SHALL pulse err and ignore bits until csb rises.
REQ-014 SHALL use FSM states IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE; csb fall: IDLE->CMD; 8 bits: CMD->ADDR/IGNORE; 32 bits: ADDR->WDATA or DUMMY; 8 bits: DUMMY->RDATA; csb rise: any->IDLE.
REQ-015 SHALL, on 72nd sck rise of a write frame, start WB write: cyc=stb=1, we=1, sel=4'hF, adr, dat held until ack.
REQ-016 SHALL, on 40th sck rise of a read frame, start WB read; on ack capture wbm_dat_i into shift register.
REQ-017 SHALL drop cyc/stb on the clock after ack; exactly one WB cycle per valid frame.
REQ-018 SHALL, if no ack within TIMEOUT clocks, drop cyc/stb and pulse err; read data then = 32'hDEADBEEF.
REQ-019 SHALL, if read ack not received before last dummy-bit sck fall, shift out 32'hDEADBEEF and pulse err; late ack SHALL complete the cycle and be discarded.
REQ-020 SHALL drive sdoenb=0 only in RDATA; sdo MSB valid after last dummy-bit fall; sdo=0 whenever sdoenb=1.
REQ-021 SHALL, on csb rise before write frame completes, abort without WB write and without err.
REQ-022 SHALL, on csb rise during an outstanding WB cycle, complete that cycle (ack or timeout) before accepting a new frame; csb fall while WB busy SHALL be ignored until csb next rises.
REQ-023 SHALL ignore sck edges beyond frame length until csb rises.
REQ-024 SHALL assert busy from csb fall until IDLE with no WB cycle outstanding.

Reset
REQ-025 SHALL on wb_rst_i: FSM=IDLE, counters=0, cyc/stb/we=0, sel=0, adr/dat=0, sdo=0, sdoenb=1, busy=0, err=0, synchronisers to idle (csb=1, sck=0).
REQ-026 SHALL, on reset mid-frame or mid-WB-cycle, drop cyc/stb immediately and ignore the frame until csb next rises.

Structure
REQ-027 SHALL place cmd codes (0x02, 0x03), 32'hDEADBEEF, and FSM state encoding in shared package spi_wb_pkg.
REQ-028 SHALL use one sub-module spi_sync_edge (synchroniser + rise/fall detect) instanced for sck, csb, sdi.

Verification
REQ-029 Write frame 0x02, adr 0x3000_0010, data 0xA5A5_1234, ack after 3 clks -> one WB write with those values, sel=F, no err.
REQ-030 Read frame 0x03, adr 0x3000_0004, ack data 0x1234_5678 after 2 clks -> sdo shifts 0x1234_5678 MSB first, sdoenb low only 32 bits.
REQ-031 Read with ack withheld -> 0xDEADBEEF shifted out, err pulses, cyc drops after TIMEOUT clocks.
REQ-032 Cmd 0x55 -> err pulse, no WB cycle, sdoenb stays 1.
REQ-033 Write frame, csb rises after 60 bits -> no WB cycle, next valid write frame executes normally.
REQ-034 wb_rst_i asserted during WB read -> cyc/stb=0 next clock, all outputs at reset values.

Source files
------------

// File: rtl/spi_wb_pkg.sv
// Shared definitions for the SPI-to-Wishbone target: command codes,
// the substitute read word, frame bit positions and the frame FSM encoding.
package spi_wb_pkg;

  localparam logic [7:0]  CMD_WRITE   = 8'h02;
  localparam logic [7:0]  CMD_READ    = 8'h03;
  localparam logic [31:0] RD_ERR_DATA = 32'hDEADBEEF;

  // Values of the rise counter (rises seen so far) at the relevant edges.
  // The *_LAST values are tested on the rise that completes the field.
  // The *_END values are tested on the falls after rises 48 and 80.
  localparam logic [6:0] CMD_LAST   = 7'd7;
  localparam logic [6:0] ADDR_LAST  = 7'd39;
  localparam logic [6:0] WDATA_LAST = 7'd71;
  localparam logic [6:0] DUMMY_END  = 7'd48;
  localparam logic [6:0] RDATA_END  = 7'd80;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    WDATA  = 3'd3,
    DUMMY  = 3'd4,
    RDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

endpackage

// File: rtl/spi_wb_target_if.sv
// Wishbone initiator bundle used between the SPI target and the bus fabric.
interface spi_wb_target_if #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32
);
  logic                 wbm_cyc_o;
  logic                 wbm_stb_o;
  logic                 wbm_we_o;
  logic [3:0]           wbm_sel_o;
  logic [ADR_WIDTH-1:0] wbm_adr_o;
  logic [DAT_WIDTH-1:0] wbm_dat_o;
  logic [DAT_WIDTH-1:0] wbm_dat_i;
  logic                 wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with single-cycle
// rise/fall strobes derived from the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the chain; reset parks it at the idle pin level
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign lvl  = chain[STAGES-1];
  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;
endmodule

// File: rtl/spi_wb_target.sv
// SPI mode-0 target that turns write/read frames into single Wishbone
// cycles. All SPI pins are oversampled in the wb_clk_i domain.
module spi_wb_target
  import spi_wb_pkg::*;
#(
  parameter int ADR_WIDTH   = 32,
  parameter int DAT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            sck,
  input  logic            csb,
  input  logic            sdi,
  output logic            sdo,
  output logic            sdoenb,
  output logic            busy,
  output logic            err,
  spi_wb_target_if.master wbm
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic sck_unused_lvl, sck_rise, sck_fall;
  logic csb_lvl, csb_rise, csb_fall;
  logic sdi_lvl, sdi_unused_rise, sdi_unused_fall;

  state_t state, state_nxt;
  logic [6:0]  bit_cnt;
  logic        is_read;
  logic [30:0] rx_sr;
  logic [31:0] rx_word;
  logic [31:0] adr_hold;
  logic [SYNC_STAGES-1:0] settle;
  logic        armed;

  logic start_wr, start_rd, cmd_err, late_err, load_sdo, shift_sdo;

  logic                 cyc, stb, we;
  logic [3:0]           sel;
  logic [ADR_WIDTH-1:0] adr;
  logic [DAT_WIDTH-1:0] dat;
  logic [TMR_W-1:0]     timer;
  logic                 wb_timeout;
  logic [31:0]          rdata;
  logic                 rdata_valid;

  logic        sdo_r;
  logic [30:0] tx_sr;
  logic [31:0] tx_word;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(sck),
    .lvl(sck_unused_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csb (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(csb),
    .lvl(csb_lvl), .rise(csb_rise), .fall(csb_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clk(wb_clk_i), .rst(wb_rst_i), .din(sdi),
    .lvl(sdi_lvl), .rise(sdi_unused_rise), .fall(sdi_unused_fall)
  );

  assign rx_word = {rx_sr, sdi_lvl};

  // Arm frame starts only once the csb chain has flushed and shows the pin
  // high, so a frame already running across a reset is never picked up mid-way
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= SYNC_STAGES'({settle, 1'b1});
      if (settle[SYNC_STAGES-1] && csb_lvl) armed <= 1'b1;
    end
  end

  // Frame state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Frame decode: next state plus single-cycle strobes for the WB and sdo logic
  always_comb begin
    state_nxt = state;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    cmd_err   = 1'b0;
    late_err  = 1'b0;
    load_sdo  = 1'b0;
    shift_sdo = 1'b0;
    if (csb_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (csb_fall) state_nxt = (armed && !cyc) ? CMD : IGNORE;
        CMD: if (sck_rise && bit_cnt == CMD_LAST) begin
          if (rx_word[7:0] == CMD_WRITE || rx_word[7:0] == CMD_READ) begin
            state_nxt = ADDR;
          end else begin
            state_nxt = IGNORE;
            cmd_err   = 1'b1;
          end
        end
        ADDR: if (sck_rise && bit_cnt == ADDR_LAST) begin
          state_nxt = is_read ? DUMMY : WDATA;
          start_rd  = is_read;
        end
        WDATA: if (sck_rise && bit_cnt == WDATA_LAST) begin
          state_nxt = IGNORE;
          start_wr  = 1'b1;
        end
        DUMMY: if (sck_fall && bit_cnt == DUMMY_END) begin
          state_nxt = RDATA;
          load_sdo  = 1'b1;
          late_err  = !rdata_valid;
        end
        RDATA: if (sck_fall) begin
          if (bit_cnt == RDATA_END) state_nxt = IGNORE;
          else                      shift_sdo = 1'b1;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Rise counter and command latch
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bit_cnt <= '0;
      is_read <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == CMD)
        bit_cnt <= '0;
      else if (sck_rise && state != IDLE && state != IGNORE)
        bit_cnt <= bit_cnt + 7'd1;
      if (state == CMD && sck_rise && bit_cnt == CMD_LAST)
        is_read <= (rx_word[7:0] == CMD_READ);
    end
  end

  // Receive shifter and address hold for the write data phase
  always_ff @(posedge wb_clk_i) begin
    if (sck_rise && (state == CMD || state == ADDR || state == WDATA))
      rx_sr <= rx_word[30:0];
    if (state == ADDR && sck_rise && bit_cnt == ADDR_LAST)
      adr_hold <= rx_word;
  end

  assign wb_timeout = cyc && !wbm.wbm_ack_i && (timer == TMR_W'(TIMEOUT - 1));

  // Wishbone engine: one cycle per start strobe, ended by ack or timeout
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cyc         <= 1'b0;
      stb         <= 1'b0;
      we          <= 1'b0;
      sel         <= 4'h0;
      adr         <= '0;
      dat         <= '0;
      timer       <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else if (start_wr || start_rd) begin
      cyc   <= 1'b1;
      stb   <= 1'b1;
      we    <= start_wr;
      sel   <= 4'hF;
      adr   <= start_wr ? ADR_WIDTH'(adr_hold) : ADR_WIDTH'(rx_word);
      dat   <= start_wr ? DAT_WIDTH'(rx_word) : '0;
      timer <= '0;
      if (start_rd) rdata_valid <= 1'b0;
    end else if (cyc) begin
      if (wbm.wbm_ack_i || wb_timeout) begin
        cyc <= 1'b0;
        stb <= 1'b0;
        we  <= 1'b0;
        sel <= 4'h0;
        if (!we) begin
          rdata       <= wbm.wbm_ack_i ? 32'(wbm.wbm_dat_i) : RD_ERR_DATA;
          rdata_valid <= 1'b1;
        end
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Read data is committed at the last dummy fall; a later ack cannot change it
  assign tx_word = rdata_valid ? rdata : RD_ERR_DATA;

  // Transmit shifter: MSB loaded at the last dummy fall, then one bit per fall
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sdo_r <= 1'b0;
      tx_sr <= '0;
    end else if (load_sdo) begin
      sdo_r <= tx_word[31];
      tx_sr <= tx_word[30:0];
    end else if (shift_sdo) begin
      sdo_r <= tx_sr[30];
      tx_sr <= {tx_sr[29:0], 1'b0};
    end
  end

  // Error strobe: bad command, read data not ready in time, or bus timeout
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) err <= 1'b0;
    else          err <= cmd_err | late_err | wb_timeout;
  end

  assign sdoenb = (state != RDATA);
  assign sdo    = sdo_r & ~sdoenb;
  assign busy   = (state != IDLE) | cyc;

  assign wbm.wbm_cyc_o = cyc;
  assign wbm.wbm_stb_o = stb;
  assign wbm.wbm_we_o  = we;
  assign wbm.wbm_sel_o = sel;
  assign wbm.wbm_adr_o = adr;
  assign wbm.wbm_dat_o = dat;
endmodule

// File: tb/tb_spi_wb_target.sv
// Bench for spi_wb_target: an SPI initiator driven from tasks, a Wishbone
// target model that logs every bus cycle, and per-scenario checks.
module tb_spi_wb_target;
  import spi_wb_pkg::*;

  localparam int HALF = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  logic clk = 1'b0;
  logic rst, sck, csb, sdi, sdo, sdoenb, busy, err;

  spi_wb_target_if #(.ADR_WIDTH(32), .DAT_WIDTH(32)) wb ();

  spi_wb_target #(.ADR_WIDTH(32), .DAT_WIDTH(32), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .sck(sck), .csb(csb), .sdi(sdi),
    .sdo(sdo), .sdoenb(sdoenb), .busy(busy), .err(err), .wbm(wb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  txn_t exp_q[$];
  txn_t obs_arr[0:15];
  int   obs_total = 0;
  int   obs_rd = 0;

  int          ack_delay = 0;
  logic [31:0] ack_data = '0;
  int err_total = 0, enb_low_total = 0, sdo_viol_total = 0, last_cyc_len = 0;

  // Wishbone target model and output monitor, sampled 1ns after each rising edge
  initial begin : wb_model
    int wait_cnt, cyc_len;
    bit in_txn, ack_sent;
    wait_cnt = 0; cyc_len = 0; in_txn = 0; ack_sent = 0;
    wb.wbm_ack_i = 1'b0;
    wb.wbm_dat_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (wb.wbm_ack_i) wb.wbm_ack_i = 1'b0;
      if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
        if (!in_txn) begin
          obs_arr[obs_total % 16] = '{wb.wbm_we_o, wb.wbm_adr_o, wb.wbm_dat_o, wb.wbm_sel_o};
          obs_total = obs_total + 1;
          in_txn = 1; wait_cnt = 0; cyc_len = 0; ack_sent = 0;
        end
        cyc_len++;
        wait_cnt++;
        if (!ack_sent && ack_delay > 0 && wait_cnt == ack_delay) begin
          wb.wbm_ack_i = 1'b1;
          wb.wbm_dat_i = ack_data;
          ack_sent = 1;
        end
      end else if (in_txn) begin
        in_txn = 0;
        last_cyc_len = cyc_len;
      end
      if (err) err_total++;
      if (!sdoenb) enb_low_total++;
      if (sdoenb && sdo) sdo_viol_total++;
    end
  end

  initial begin : watchdog
    #700000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 initiator: sdi changes with sck low, sdo sampled just before each rise
  task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] adr,
                           input logic [31:0] data, input bit rd_frame,
                           input int nbits, input bit release_csb,
                           output logic [31:0] rd_word);
    logic [79:0] tx;
    tx = rd_frame ? {cmd, adr, 40'h0} : {cmd, adr, data, 8'h0};
    rd_word = '0;
    csb = 1'b0;
    tick(HALF);
    for (int i = 0; i < nbits; i++) begin
      sdi = tx[79-i];
      tick(HALF);
      if (i >= 48) rd_word = {rd_word[30:0], sdo};
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
    tick(HALF);
    sdi = 1'b0;
    if (release_csb) begin
      csb = 1'b1;
      tick(4 * HALF);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy && !wb.wbm_cyc_o) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic take_txn(output txn_t exp, output txn_t got, output bit have);
    exp  = exp_q.pop_front();
    have = (obs_total > obs_rd);
    got  = have ? obs_arr[obs_rd % 16] : '0;
    if (have) obs_rd++;
  endtask

  task automatic test_reset();
    rst = 1'b1; csb = 1'b1; sck = 1'b0; sdi = 1'b0;
    tick(4);
    checks++;
    if ({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_sel_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b required 0000000",
               {wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_sel_o});
    end
    checks++;
    if ({wb.wbm_adr_o, wb.wbm_dat_o} !== 64'h0) begin
      failures++;
      $display("FAIL reset_adr_dat: got %h required 0", {wb.wbm_adr_o, wb.wbm_dat_o});
    end
    checks++;
    if (sdoenb !== 1'b1 || sdo !== 1'b0) begin
      failures++;
      $display("FAIL reset_sdo: got sdoenb=%b sdo=%b required 1/0", sdoenb, sdo);
    end
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy_err: got busy=%b err=%b required 0/0", busy, err);
    end
    rst = 1'b0;
    tick(8);
    checks++;
    if (busy !== 1'b0 || wb.wbm_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got busy=%b cyc=%b required 0/0", busy, wb.wbm_cyc_o);
    end
  endtask

  task automatic run_write(input string name, input logic [31:0] a, input logic [31:0] d,
                           input int dly);
    logic [31:0] rd;
    txn_t e, g;
    bit ok, have;
    int e0;
    ack_delay = dly;
    e0 = err_total;
    exp_q.push_back('{1'b1, a, d, 4'hF});
    spi_frame(CMD_WRITE, a, d, 1'b0, 72, 1'b1, rd);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_idle: got busy required idle", name); end
    take_txn(e, g, have);
    checks++;
    if (!have || g !== e) begin
      failures++;
      $display("FAIL %s_txn: got we=%b adr=%h dat=%h sel=%h (present=%0d) required we=%b adr=%h dat=%h sel=%h",
               name, g.we, g.adr, g.dat, g.sel, have, e.we, e.adr, e.dat, e.sel);
    end
    checks++;
    if (err_total != e0 || last_cyc_len != dly) begin
      failures++;
      $display("FAIL %s_err_len: got err=%0d cyc_len=%0d required err=0 cyc_len=%0d",
               name, err_total - e0, last_cyc_len, dly);
    end
  endtask

  task automatic test_write();
    run_write("write", 32'h3000_0010, 32'hA5A5_1234, 3);
  endtask

  task automatic run_read(input string name, input logic [31:0] a, input int dly,
                          input logic [31:0] want, input int want_err, input int want_len);
    logic [31:0] rd;
    txn_t e, g;
    bit ok, have;
    int e0, n0, v0;
    ack_delay = dly;
    e0 = err_total; n0 = enb_low_total; v0 = sdo_viol_total;
    exp_q.push_back('{1'b0, a, 32'h0, 4'hF});
    spi_frame(CMD_READ, a, 32'h0, 1'b1, 80, 1'b1, rd);
    wait_idle(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_idle: got busy required idle", name); end
    take_txn(e, g, have);
    checks++;
    if (!have || {g.we, g.adr, g.sel} !== {e.we, e.adr, e.sel}) begin
      failures++;
      $display("FAIL %s_txn: got we=%b adr=%h sel=%h (present=%0d) required we=0 adr=%h sel=f",
               name, g.we, g.adr, g.sel, have, e.adr);
    end
    checks++;
    if (rd !== want) begin failures++; $display("FAIL %s_sdo_word: got %h required %h", name, rd, want); end
    checks++;
    if (enb_low_total - n0 != 512 || sdo_viol_total != v0) begin
      failures++;
      $display("FAIL %s_sdoenb: got low=%0d viol=%0d required low=512 viol=0",
               name, enb_low_total - n0, sdo_viol_total - v0);
    end
    checks++;
    if (err_total - e0 != want_err || last_cyc_len != want_len) begin
      failures++;
      $display("FAIL %s_err_len: got err=%0d cyc_len=%0d required err=%0d cyc_len=%0d",
               name, err_total - e0, last_cyc_len, want_err, want_len);
    end
  endtask

  task automatic test_read();
    ack_data = 32'h1234_5678;
    run_read("read", 32'h3000_0004, 2, 32'h1234_5678, 0, 2);
  endtask

  task automatic test_timeout();
    ack_data = 32'h0BAD_F00D;
    run_read("timeout", 32'h3000_0008, -1, RD_ERR_DATA, 2, 255);
  endtask

  task automatic test_late_ack();
    ack_data = 32'h7777_1111;
    run_read("late_ack", 32'h3000_000C, 200, RD_ERR_DATA, 1, 200);
  endtask

  task automatic test_bad_cmd();
    logic [31:0] rd;
    bit ok;
    int e0, n0, t0;
    e0 = err_total; n0 = enb_low_total; t0 = obs_total;
    spi_frame(8'h55, 32'h3000_0000, 32'h0, 1'b1, 80, 1'b1, rd);
    wait_idle(ok);
    checks++;
    if (!ok || obs_total != t0) begin
      failures++;
      $display("FAIL bad_cmd_bus: got idle=%0d cycles=%0d required idle=1 cycles=0", ok, obs_total - t0);
    end
    checks++;
    if (err_total - e0 != 1 || enb_low_total != n0) begin
      failures++;
      $display("FAIL bad_cmd_err: got err=%0d sdoenb_low=%0d required err=1 sdoenb_low=0",
               err_total - e0, enb_low_total - n0);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd;
    bit ok;
    int e0, t0;
    e0 = err_total; t0 = obs_total;
    spi_frame(CMD_WRITE, 32'h3000_0020, 32'hDEAD_0001, 1'b0, 60, 1'b1, rd);
    wait_idle(ok);
    checks++;
    if (!ok || obs_total != t0 || err_total != e0) begin
      failures++;
      $display("FAIL abort: got idle=%0d cycles=%0d err=%0d required idle=1 cycles=0 err=0",
               ok, obs_total - t0, err_total - e0);
    end
    run_write("after_abort", 32'h3000_0024, 32'h0F0F_5A5A, 1);
  endtask

  task automatic test_back_to_back();
    run_write("b2b_a", 32'h3000_0100, 32'h0000_0001, 4);
    run_write("b2b_b", 32'h3FFF_FFFC, 32'hFFFF_FFFF, 2);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    txn_t e, g;
    bit have;
    int t0;
    ack_delay = -1;
    exp_q.push_back('{1'b0, 32'h3000_0040, 32'h0, 4'hF});
    spi_frame(CMD_READ, 32'h3000_0040, 32'h0, 1'b1, 44, 1'b0, rd);
    checks++;
    if (wb.wbm_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_cyc_open: got cyc=%b required 1", wb.wbm_cyc_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_we_o, wb.wbm_sel_o} !== 7'b0 || wb.wbm_adr_o !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_bus: got cyc=%b stb=%b adr=%h required 0/0/0",
               wb.wbm_cyc_o, wb.wbm_stb_o, wb.wbm_adr_o);
    end
    checks++;
    if (sdoenb !== 1'b1 || sdo !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_pins: got sdoenb=%b sdo=%b busy=%b err=%b required 1/0/0/0",
               sdoenb, sdo, busy, err);
    end
    take_txn(e, g, have);
    checks++;
    if (!have || {g.we, g.adr} !== {e.we, e.adr}) begin
      failures++;
      $display("FAIL mid_txn: got we=%b adr=%h required we=0 adr=%h", g.we, g.adr, e.adr);
    end
    @(negedge clk);
    rst = 1'b0;
    t0 = obs_total;
    tick(10);
    for (int i = 0; i < 80; i++) begin
      sdi = i[0];
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
    checks++;
    if (obs_total != t0 || wb.wbm_cyc_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_ignored: got cycles=%0d cyc=%b required 0/0", obs_total - t0, wb.wbm_cyc_o);
    end
    csb = 1'b1;
    tick(4 * HALF);
    run_write("after_reset", 32'h3000_0044, 32'hCAFE_0042, 3);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_abort();
    test_timeout();
    test_late_ack();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
